// File: rtl/palt_nios_sys_nios_oci_trace_monitor.sv
// Capture/drain monitor for the OCI DCT trace path: buffers {dct_count, dct_buffer} words in a
// show-ahead FIFO, drains them over valid/ready, and sequences end-of-test RUN -> FLUSH -> ENDED.
module palt_nios_sys_nios_oci_trace_monitor #(
    parameter int SLOT_W = 10,
    parameter int SLOTS  = 3,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int STAT_W = 16,
    localparam int DCT_W = SLOT_W * SLOTS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dct_valid,
    input  logic [DCT_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              test_has_ended,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [DCT_W-1:0]  trc_data,
    output logic [CNT_W-1:0]  trc_count,
    output logic [AW:0]       level,
    output logic [STAT_W-1:0] drop_cnt,
    output logic [STAT_W-1:0] bad_cnt,
    output logic [STAT_W-1:0] word_cnt,
    output logic [1:0]        state,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W+DCT_W-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   empty, full, in_run, count_ok, count_bad;
    logic                   push, pop, drop, bad;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level     = wr_ptr - rd_ptr;

    assign in_run    = (state_q == ST_RUN);
    assign count_ok  = (dct_count != '0) && (dct_count <= CNT_W'(SLOTS));
    assign count_bad = (dct_count > CNT_W'(SLOTS));

    // Room is judged on the pre-edge level; a simultaneous pop does not make space.
    assign push      = dct_valid && in_run && count_ok && !full;
    assign drop      = dct_valid && in_run && count_ok && full;
    assign bad       = dct_valid && in_run && count_bad;

    assign trc_valid = !empty && (state_q != ST_ENDED);
    assign pop       = trc_valid && trc_ready;

    assign {trc_count, trc_data} = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; contents behind empty pointers are never observed,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {dct_count, dct_buffer};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            drop_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (push && (word_cnt != '1)) word_cnt <= word_cnt + STAT_W'(1);
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + STAT_W'(1);
            if (bad  && (bad_cnt  != '1)) bad_cnt  <= bad_cnt  + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (test_ending || test_has_ended) state_d = ST_FLUSH;
            ST_FLUSH: if (empty && test_has_ended)       state_d = ST_ENDED;
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_RUN;
        endcase
    end

    assign state = state_q;
    assign done  = (state_q == ST_ENDED);

endmodule

// File: tb/tb_palt_nios_sys_nios_oci_trace_monitor.sv
// Self-checking bench: constant vector table, directed corner sequences and randomized traffic
// compared against a queue-based reference model of the monitor.
module tb_palt_nios_sys_nios_oci_trace_monitor;

    localparam int SLOT_W = 10;
    localparam int SLOTS  = 3;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int STAT_W = 16;
    localparam int DCT_W  = SLOT_W * SLOTS;
    localparam int AW     = $clog2(DEPTH);
    localparam int SAT    = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dct_valid = 1'b0;
    logic [DCT_W-1:0]  dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              test_ending = 1'b0;
    logic              test_has_ended = 1'b0;
    logic              trc_valid;
    logic              trc_ready = 1'b0;
    logic [DCT_W-1:0]  trc_data;
    logic [CNT_W-1:0]  trc_count;
    logic [AW:0]       level;
    logic [STAT_W-1:0] drop_cnt, bad_cnt, word_cnt;
    logic [1:0]        state;
    logic              done;

    palt_nios_sys_nios_oci_trace_monitor #(
        .SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data), .trc_count(trc_count),
        .level(level), .drop_cnt(drop_cnt), .bad_cnt(bad_cnt), .word_cnt(word_cnt),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {count, data} words plus plain integer counters.
    logic [CNT_W+DCT_W-1:0] mq[$];
    int m_word, m_bad, m_drop, m_state;

    task automatic model_clear();
        mq.delete();
        m_word = 0; m_bad = 0; m_drop = 0; m_state = 0;
    endtask

    task automatic compare_model(input string tag);
        bit exp_valid;
        exp_valid = (m_state != 2) && (mq.size() > 0);
        check({tag, ".trc_valid"}, trc_valid, exp_valid);
        if (exp_valid) begin
            check({tag, ".trc_data"},  trc_data,  mq[0][DCT_W-1:0]);
            check({tag, ".trc_count"}, trc_count, mq[0][CNT_W+DCT_W-1:DCT_W]);
        end
        check({tag, ".level"},    level,    mq.size());
        check({tag, ".word_cnt"}, word_cnt, m_word);
        check({tag, ".bad_cnt"},  bad_cnt,  m_bad);
        check({tag, ".drop_cnt"}, drop_cnt, m_drop);
        check({tag, ".state"},    state,    m_state);
        check({tag, ".done"},     done,     m_state == 2);
    endtask

    // Advance one clock: the model consumes the pre-edge inputs, then the DUT is sampled
    // 1 time unit after the edge.
    task automatic cycle(input string tag);
        int  n;
        bit  pop_m, push_m;
        n      = mq.size();
        pop_m  = (m_state != 2) && (n > 0) && trc_ready;
        push_m = 1'b0;
        if (dct_valid && m_state == 0 && dct_count != 0) begin
            if (dct_count > SLOTS)   begin if (m_bad  < SAT) m_bad++;  end
            else if (n == DEPTH)     begin if (m_drop < SAT) m_drop++; end
            else                     push_m = 1'b1;
        end
        if (m_state == 0 && (test_ending || test_has_ended)) m_state = 1;
        else if (m_state == 1 && n == 0 && test_has_ended)  m_state = 2;
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            mq.push_back({dct_count, dct_buffer});
            if (m_word < SAT) m_word++;
        end
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic idle_inputs();
        dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        trc_ready = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_clear();
        #2;
        check("rst.level", level, 0);
        check("rst.trc_valid", trc_valid, 0);
        check("rst.state", state, 0);
        check("rst.done", done, 0);
        check("rst.counters", {word_cnt, bad_cnt, drop_cnt}, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drive_word(input logic v, input int cnt, input logic rdy);
        dct_valid  = v;
        dct_count  = CNT_W'(cnt);
        dct_buffer = DCT_W'($urandom);
        trc_ready  = rdy;
    endtask

    typedef struct {
        logic v; int cnt; logic rdy; logic te; logic the;
        int lvl; int wc; int bc; int dc; int st;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 1,  0, 0, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 0,  0, 0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 4,  0, 0, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{1, 15, 0, 0, 0, 1, 1, 2, 0, 0};
        tbl[4]  = '{1, 3,  1, 0, 0, 1, 2, 2, 0, 0};
        tbl[5]  = '{0, 0,  1, 0, 0, 0, 2, 2, 0, 0};
        tbl[6]  = '{1, 2,  0, 1, 0, 1, 3, 2, 0, 1};
        tbl[7]  = '{1, 2,  0, 0, 0, 1, 3, 2, 0, 1};
        tbl[8]  = '{0, 0,  1, 0, 1, 0, 3, 2, 0, 1};
        tbl[9]  = '{0, 0,  1, 0, 1, 0, 3, 2, 0, 2};
        tbl[10] = '{1, 1,  1, 0, 1, 0, 3, 2, 0, 2};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive_word(tbl[i].v, tbl[i].cnt, tbl[i].rdy);
            test_ending    = tbl[i].te;
            test_has_ended = tbl[i].the;
            cycle("tbl");
            check($sformatf("tbl%0d.level", i), level, tbl[i].lvl);
            check($sformatf("tbl%0d.word_cnt", i), word_cnt, tbl[i].wc);
            check($sformatf("tbl%0d.bad_cnt", i), bad_cnt, tbl[i].bc);
            check($sformatf("tbl%0d.drop_cnt", i), drop_cnt, tbl[i].dc);
            check($sformatf("tbl%0d.state", i), state, tbl[i].st);
        end

        // Streaming with the sink always ready: each word appears the cycle after its push.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_word(1'b1, (i % 3) + 1, 1'b1);
            cycle("stream");
            check("stream.trc_valid", trc_valid, 1);
        end
        drive_word(1'b0, 0, 1'b1);
        cycle("stream_end");
        check("stream.word_cnt", word_cnt, 5);
        check("stream.level", level, 0);

        // Overfill with the sink stalled, then push and pop together on a full FIFO.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive_word(1'b1, (i % 3) + 1, 1'b0);
            cycle("fill");
        end
        check("fill.level", level, DEPTH);
        check("fill.drop_cnt", drop_cnt, 2);
        drive_word(1'b1, 2, 1'b1);
        cycle("full_pushpop");
        check("full_pushpop.drop_cnt", drop_cnt, 3);
        check("full_pushpop.level", level, DEPTH - 1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_word(1'b0, 0, 1'b1);
            cycle("drain");
        end
        check("drain.level", level, 0);

        // Asynchronous reset in the middle of a flush.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_word(1'b1, 1, 1'b0);
            cycle("pre_rst");
        end
        drive_word(1'b0, 0, 1'b1);
        test_ending = 1'b1;
        cycle("pre_rst_flush");
        check("pre_rst.level", level, 7);
        check("pre_rst.state", state, 1);
        do_reset();

        // Randomized traffic followed by an end-of-test flush.
        for (int i = 0; i < 1500; i++) begin
            drive_word($urandom_range(0, 9) < 7, $urandom_range(0, 5), $urandom_range(0, 1));
            cycle("rand");
        end
        drive_word(1'b1, 2, $urandom_range(0, 1));
        test_ending = 1'b1;
        cycle("rand_end");
        test_ending    = 1'b0;
        test_has_ended = 1'b1;
        begin
            int budget;
            budget = 0;
            while (!done && budget < 300) begin
                drive_word($urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 1));
                cycle("flush");
                budget++;
            end
            check("flush.reached_ended", done, 1);
        end
        for (int i = 0; i < 3; i++) begin
            drive_word(1'b1, 1, 1'b1);
            cycle("ended");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
